// File: rtl/chan_pkt_reader_pkg.sv
// Shared TX definitions: header field positions, timestamp sentinel, word cap, reader FSM encoding.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package chan_pkt_reader_pkg;

    // Header word 0 field positions
    localparam int HDR_SOB_BIT = 28;
    localparam int HDR_EOB_BIT = 27;
    localparam int HDR_LEN_MSB = 8;
    localparam int HDR_LEN_LSB = 0;

    // Timestamp value meaning "send immediately"
    localparam logic [31:0] TS_NOW = 32'hFFFF_FFFF;

    // Payload word cap: 128-word slot minus the 2 header words
    localparam int MAX_WORDS = 126;
    localparam int CNT_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TS   = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4,
        ST_DROP = 3'd5
    } rd_state_t;

    // Byte length to 32-bit word count, rounded up and capped at MAX_WORDS
    function automatic logic [CNT_W-1:0] len_to_words(input logic [8:0] len);
        logic [9:0] words;
        words = ({1'b0, len} + 10'd3) >> 2;
        if (words > 10'(MAX_WORDS)) begin
            return CNT_W'(MAX_WORDS);
        end
        return words[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/chan_pkt_reader_if.sv
// Bundle between a channel packet reader and its packet buffer / DAC sample port.
// Latency: n/a (wires only).
// Backpressure: rdreq pops a show-ahead word, skip retires a slot, tx_strobe paces the samples.
interface chan_pkt_reader_if;
    import chan_pkt_reader_pkg::*;

    logic [31:0] fifodata;
    logic        pkt_waiting;
    logic        rdreq;
    logic        skip;
    logic        tx_strobe;
    logic [31:0] adc_time;
    logic [15:0] tx_i;
    logic [15:0] tx_q;
    logic        underrun;
    logic        dropped;
    logic        in_burst;

    // Reader side
    modport master (
        input  fifodata, pkt_waiting, tx_strobe, adc_time,
        output rdreq, skip, tx_i, tx_q, underrun, dropped, in_burst
    );

    // Buffer / DAC side
    modport slave (
        output fifodata, pkt_waiting, tx_strobe, adc_time,
        input  rdreq, skip, tx_i, tx_q, underrun, dropped, in_burst
    );

endinterface

// File: rtl/chan_ts_compare.sv
// Timestamp decision: immediate sentinel, exact match, and late (timestamp already in the past).
// Latency: combinational.
// Backpressure: none.
module chan_ts_compare
    import chan_pkt_reader_pkg::*;
(
    input  logic [31:0] ts,
    input  logic [31:0] now,
    output logic        ts_now,
    output logic        ts_match,
    output logic        ts_late
);

    logic [31:0] ts_diff;

    // Wrapping difference: a negative result means the slot time has already passed
    assign ts_diff  = ts - now;
    assign ts_now   = (ts == TS_NOW);
    assign ts_match = (ts == now);
    assign ts_late  = ts_diff[31] && !ts_now;

endmodule

// File: rtl/chan_pkt_reader.sv
// Per-channel TX packet reader: parse 2-word header, hold for timestamp, stream I/Q per DAC strobe.
// Latency: IDLE->TS->WAIT->SEND is 3 cycles minimum; a sample lands on tx_i/tx_q 1 cycle after its strobe.
// Backpressure: one payload word popped per tx_strobe in SEND; a strobe with no sample outputs 0 (underrun in burst).
module chan_pkt_reader
    import chan_pkt_reader_pkg::*;
(
    input  logic               txclk,
    input  logic               reset,
    chan_pkt_reader_if.master  bus
);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic             sob_q;
    logic             eob_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ts_q;
    logic [15:0]      tx_i_q;
    logic [15:0]      tx_q_q;
    logic             underrun_q;
    logic             in_burst_q;
    logic             ts_imm;
    logic             ts_match;
    logic             ts_late;
    logic             go_send;
    logic             send_strobe;

    chan_ts_compare u_ts_cmp (
        .ts       (ts_q),
        .now      (bus.adc_time),
        .ts_now   (ts_imm),
        .ts_match (ts_match),
        .ts_late  (ts_late)
    );

    assign go_send     = (state == ST_WAIT) && (ts_imm || ts_match);
    assign send_strobe = (state == ST_SEND) && bus.tx_strobe;

    assign bus.tx_i     = tx_i_q;
    assign bus.tx_q     = tx_q_q;
    assign bus.underrun = underrun_q;
    assign bus.in_burst = in_burst_q;

    // Next state plus the combinational buffer controls (rdreq, skip, dropped)
    always_comb begin
        state_nxt   = state;
        bus.rdreq   = 1'b0;
        bus.skip    = 1'b0;
        bus.dropped = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.pkt_waiting) begin
                    bus.rdreq = 1'b1;
                    state_nxt = ST_TS;
                end
            end
            ST_TS: begin
                bus.rdreq = 1'b1;
                state_nxt = (cnt_q == '0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (ts_imm || ts_match) begin
                    state_nxt = ST_SEND;
                end else if (ts_late) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_SEND: begin
                if (bus.tx_strobe) begin
                    bus.rdreq = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                bus.skip  = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                bus.skip    = 1'b1;
                bus.dropped = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge txclk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Header capture and remaining-word counter
    always_ff @(posedge txclk) begin
        if (reset) begin
            sob_q <= 1'b0;
            eob_q <= 1'b0;
            cnt_q <= '0;
            ts_q  <= '0;
        end else begin
            if (state == ST_IDLE && bus.pkt_waiting) begin
                sob_q <= bus.fifodata[HDR_SOB_BIT];
                eob_q <= bus.fifodata[HDR_EOB_BIT];
                cnt_q <= len_to_words(bus.fifodata[HDR_LEN_MSB:HDR_LEN_LSB]);
            end
            if (state == ST_TS) begin
                ts_q <= bus.fifodata;
            end
            if (send_strobe) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Burst tracking: opens when an SOB packet starts sending, closes on EOB retire or a drop
    always_ff @(posedge txclk) begin
        if (reset) begin
            in_burst_q <= 1'b0;
        end else if (go_send && sob_q) begin
            in_burst_q <= 1'b1;
        end else if ((state == ST_DONE && eob_q) || state == ST_DROP) begin
            in_burst_q <= 1'b0;
        end
    end

    // Sample output and underrun flag, both updated only on a strobe
    always_ff @(posedge txclk) begin
        if (reset) begin
            tx_i_q     <= '0;
            tx_q_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= bus.tx_strobe && (state != ST_SEND) && in_burst_q;
            if (send_strobe) begin
                tx_i_q <= bus.fifodata[15:0];
                tx_q_q <= bus.fifodata[31:16];
            end else if (bus.tx_strobe) begin
                tx_i_q <= '0;
                tx_q_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_chan_pkt_reader.sv
// Bench for chan_pkt_reader: 4-slot buffer model, scenario tasks, in_burst/word-count reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_chan_pkt_reader;
    import chan_pkt_reader_pkg::*;

    logic txclk = 1'b0;
    logic reset = 1'b1;
    always #5 txclk = ~txclk;

    chan_pkt_reader_if bus ();

    chan_pkt_reader dut (
        .txclk (txclk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Packet buffer model: 4 slots of 128 words, show-ahead read word, skip retires a slot
    logic [31:0] slot_mem [4][128];
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int rd_word = 0;

    assign bus.pkt_waiting = (wr_cnt != rd_cnt);
    assign bus.fifodata    = slot_mem[rd_cnt % 4][rd_word % 128];

    // Buffer pointer update; shares the reader's reset, which flushes it
    always @(posedge txclk) begin
        if (reset) begin
            rd_word <= 0;
            rd_cnt  <= wr_cnt;
        end else if (bus.skip) begin
            rd_cnt  <= rd_cnt + 1;
            rd_word <= 0;
        end else if (bus.rdreq) begin
            rd_word <= rd_word + 1;
        end
    end

    // Event counters sampled mid-cycle
    int n_rd = 0, n_skip = 0, n_drop = 0, n_under = 0;
    bit both_seen = 1'b0;
    always @(negedge txclk) begin
        if (!reset) begin
            if (bus.rdreq)    n_rd++;
            if (bus.skip)     n_skip++;
            if (bus.dropped)  n_drop++;
            if (bus.underrun) n_under++;
            if (bus.rdreq && bus.skip) both_seen = 1'b1;
        end
    end

    // Reference in_burst state
    bit burst_m = 1'b0;

    function automatic int exp_words(input int len);
        int w;
        w = (len + 3) / 4;
        if (w > 126) w = 126;
        return w;
    endfunction

    task automatic tick();
        @(posedge txclk);
        #1;
        bus.adc_time = bus.adc_time + 32'd1;
    endtask

    task automatic load_pkt(input bit sob, input bit eob, input logic [8:0] len,
                            input logic [31:0] ts, input bit fixed, output int slot);
        slot = wr_cnt % 4;
        slot_mem[slot][0] = {3'b000, sob, eob, 18'd0, len};
        slot_mem[slot][1] = ts;
        for (int k = 0; k < 126; k++) begin
            if (fixed) slot_mem[slot][2+k] = {16'(2*k+2), 16'(2*k+1)};
            else       slot_mem[slot][2+k] = $urandom;
        end
        wr_cnt = wr_cnt + 1;
    endtask

    // Run one immediate packet already at the buffer head; entered right after a clock edge, DUT in IDLE
    task automatic drive_pkt(input bit sob, input bit eob, input int len, input int slot, input int maxgap);
        int nw, rd0, sk0, sent, pending, guard;
        bit strobe;
        logic [31:0] want;
        nw  = exp_words(len);
        rd0 = n_rd;
        sk0 = n_skip;
        // accept cycle
        @(negedge txclk);
        checks++;
        if (bus.rdreq !== 1'b1) begin errors++; $display("FAIL accept_rdreq got %b want 1", bus.rdreq); end
        checks++;
        if (bus.in_burst !== burst_m) begin errors++; $display("FAIL accept_in_burst got %b want %b", bus.in_burst, burst_m); end
        tick();
        // timestamp cycle
        @(negedge txclk);
        checks++;
        if (bus.rdreq !== 1'b1) begin errors++; $display("FAIL ts_rdreq got %b want 1", bus.rdreq); end
        tick();
        @(negedge txclk);
        if (nw == 0) begin
            checks++;
            if (bus.skip !== 1'b1) begin errors++; $display("FAIL zero_len_skip got %b want 1", bus.skip); end
            tick();
        end else begin
            checks++;
            if (bus.rdreq !== 1'b0 || bus.skip !== 1'b0) begin
                errors++; $display("FAIL wait_ctrl got rdreq=%b skip=%b want 0 0", bus.rdreq, bus.skip);
            end
            tick();
            if (sob) burst_m = 1'b1;
            sent = 0;
            pending = -1;
            guard = 0;
            while (sent < nw || pending >= 0) begin
                strobe = (sent < nw) && ($urandom_range(0, maxgap) == 0);
                bus.tx_strobe = strobe;
                @(negedge txclk);
                if (pending >= 0) begin
                    want = slot_mem[slot][2+pending];
                    checks++;
                    if ({bus.tx_q, bus.tx_i} !== want) begin
                        errors++; $display("FAIL sample[%0d] got %h want %h", pending, {bus.tx_q, bus.tx_i}, want);
                    end
                end else if (sent > 0) begin
                    want = slot_mem[slot][2+sent-1];
                    checks++;
                    if ({bus.tx_q, bus.tx_i} !== want) begin
                        errors++; $display("FAIL sample_hold got %h want %h", {bus.tx_q, bus.tx_i}, want);
                    end
                end
                checks++;
                if (bus.skip !== (pending == nw - 1)) begin
                    errors++; $display("FAIL send_skip got %b want %b", bus.skip, (pending == nw - 1));
                end
                checks++;
                if (bus.in_burst !== burst_m || bus.underrun !== 1'b0) begin
                    errors++; $display("FAIL send_burst got in_burst=%b underrun=%b want %b 0", bus.in_burst, bus.underrun, burst_m);
                end
                pending = strobe ? sent : -1;
                if (strobe) sent++;
                tick();
                bus.tx_strobe = 1'b0;
                guard++;
                if (guard > 5000) begin
                    checks++; errors++;
                    $display("FAIL drive_timeout got %0d words want %0d", sent, nw);
                    break;
                end
            end
        end
        if (eob) burst_m = 1'b0;
        checks++;
        if (n_rd - rd0 !== nw + 2) begin errors++; $display("FAIL rdreq_count len=%0d got %0d want %0d", len, n_rd - rd0, nw + 2); end
        checks++;
        if (n_skip - sk0 !== 1) begin errors++; $display("FAIL skip_count len=%0d got %0d want 1", len, n_skip - sk0); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge txclk);
        checks++;
        if ({bus.rdreq, bus.skip, bus.underrun, bus.dropped, bus.in_burst} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {bus.rdreq, bus.skip, bus.underrun, bus.dropped, bus.in_burst});
        end
        checks++;
        if ({bus.tx_i, bus.tx_q} !== 32'h0) begin errors++; $display("FAIL reset_tx got %h want 0", {bus.tx_i, bus.tx_q}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int s;
        load_pkt(1'b1, 1'b1, 9'd8, TS_NOW, 1'b1, s);
        drive_pkt(1'b1, 1'b1, 8, s, 2);
        @(negedge txclk);
        checks++;
        if (bus.tx_i !== 16'd3 || bus.tx_q !== 16'd4) begin
            errors++; $display("FAIL basic_last got i=%0d q=%0d want 3 4", bus.tx_i, bus.tx_q);
        end
        checks++;
        if (bus.in_burst !== 1'b0) begin errors++; $display("FAIL basic_burst_end got %b want 0", bus.in_burst); end
        tick();
    endtask

    task automatic test_wait_ts(input logic [31:0] ts);
        int s, sk0;
        tick();
        bus.adc_time = ts - 32'd12;
        load_pkt(1'b1, 1'b1, 9'd4, ts, 1'b0, s);
        sk0 = n_skip;
        tick();
        tick();
        while (bus.adc_time != ts + 32'd1) begin
            @(negedge txclk);
            checks++;
            if (bus.rdreq !== 1'b0 || bus.in_burst !== 1'b0) begin
                errors++; $display("FAIL wait_hold adc=%0d got rdreq=%b in_burst=%b want 0 0", bus.adc_time, bus.rdreq, bus.in_burst);
            end
            tick();
        end
        bus.tx_strobe = 1'b1;
        @(negedge txclk);
        checks++;
        if (bus.in_burst !== 1'b1 || bus.rdreq !== 1'b1) begin
            errors++; $display("FAIL wait_send got in_burst=%b rdreq=%b want 1 1", bus.in_burst, bus.rdreq);
        end
        tick();
        bus.tx_strobe = 1'b0;
        @(negedge txclk);
        checks++;
        if ({bus.tx_q, bus.tx_i} !== slot_mem[s][2] || bus.skip !== 1'b1) begin
            errors++; $display("FAIL wait_sample got %h skip=%b want %h 1", {bus.tx_q, bus.tx_i}, bus.skip, slot_mem[s][2]);
        end
        tick();
        checks++;
        if (n_skip - sk0 !== 1) begin errors++; $display("FAIL wait_skip_count got %0d want 1", n_skip - sk0); end
        burst_m = 1'b0;
    endtask

    task automatic test_drop();
        int sa, sb, s0, dr0;
        logic [31:0] tx_before;
        // open a burst first so the drop has something to close
        load_pkt(1'b1, 1'b0, 9'd8, TS_NOW, 1'b0, s0);
        drive_pkt(1'b1, 1'b0, 8, s0, 1);
        tx_before = {bus.tx_q, bus.tx_i};
        dr0 = n_drop;
        bus.adc_time = 32'd598;
        load_pkt(1'b1, 1'b1, 9'd16, 32'd500, 1'b0, sa);
        load_pkt(1'b0, 1'b1, 9'd12, TS_NOW, 1'b0, sb);
        tick();
        tick();
        @(negedge txclk);
        checks++;
        if (bus.rdreq !== 1'b0 || bus.skip !== 1'b0 || bus.dropped !== 1'b0) begin
            errors++; $display("FAIL drop_wait got rdreq=%b skip=%b dropped=%b want 0 0 0", bus.rdreq, bus.skip, bus.dropped);
        end
        tick();
        @(negedge txclk);
        checks++;
        if (bus.skip !== 1'b1 || bus.dropped !== 1'b1 || bus.rdreq !== 1'b0) begin
            errors++; $display("FAIL drop_pulse got skip=%b dropped=%b rdreq=%b want 1 1 0", bus.skip, bus.dropped, bus.rdreq);
        end
        checks++;
        if ({bus.tx_q, bus.tx_i} !== tx_before) begin
            errors++; $display("FAIL drop_no_sample got %h want %h", {bus.tx_q, bus.tx_i}, tx_before);
        end
        tick();
        burst_m = 1'b0;
        drive_pkt(1'b0, 1'b1, 12, sb, 1);
        checks++;
        if (n_drop - dr0 !== 1) begin errors++; $display("FAIL drop_count got %0d want 1", n_drop - dr0); end
    endtask

    task automatic test_lengths();
        int lens [7] = '{511, 505, 504, 5, 0, 4, 1};
        int s;
        foreach (lens[i]) begin
            load_pkt(1'b1, 1'b1, 9'(lens[i]), TS_NOW, 1'b0, s);
            drive_pkt(1'b1, 1'b1, lens[i], s, 0);
        end
    endtask

    task automatic test_random();
        int s, len;
        bit sob, eob;
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(0, 511);
            sob = 1'($urandom_range(0, 1));
            eob = 1'($urandom_range(0, 1));
            load_pkt(sob, eob, 9'(len), TS_NOW, 1'b0, s);
            drive_pkt(sob, eob, len, s, 2);
            repeat ($urandom_range(0, 3)) tick();
        end
        if (burst_m) begin
            load_pkt(1'b0, 1'b1, 9'd4, TS_NOW, 1'b0, s);
            drive_pkt(1'b0, 1'b1, 4, s, 0);
        end
    endtask

    task automatic test_underrun();
        int s, u0;
        load_pkt(1'b1, 1'b0, 9'd12, TS_NOW, 1'b0, s);
        drive_pkt(1'b1, 1'b0, 12, s, 1);
        u0 = n_under;
        for (int i = 0; i < 3; i++) begin
            bus.tx_strobe = 1'b1;
            tick();
            bus.tx_strobe = 1'b0;
            @(negedge txclk);
            checks++;
            if ({bus.tx_i, bus.tx_q} !== 32'h0 || bus.underrun !== 1'b1) begin
                errors++; $display("FAIL underrun_pulse got tx=%h underrun=%b want 0 1", {bus.tx_i, bus.tx_q}, bus.underrun);
            end
            tick();
            @(negedge txclk);
            checks++;
            if (bus.underrun !== 1'b0) begin errors++; $display("FAIL underrun_single got %b want 0", bus.underrun); end
            tick();
        end
        checks++;
        if (n_under - u0 !== 3) begin errors++; $display("FAIL underrun_count got %0d want 3", n_under - u0); end
        load_pkt(1'b0, 1'b1, 9'd8, TS_NOW, 1'b0, s);
        drive_pkt(1'b0, 1'b1, 8, s, 1);
        bus.tx_strobe = 1'b1;
        tick();
        bus.tx_strobe = 1'b0;
        @(negedge txclk);
        checks++;
        if (bus.underrun !== 1'b0 || bus.in_burst !== 1'b0 || {bus.tx_i, bus.tx_q} !== 32'h0) begin
            errors++; $display("FAIL idle_strobe got underrun=%b in_burst=%b tx=%h want 0 0 0", bus.underrun, bus.in_burst, {bus.tx_i, bus.tx_q});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int s, sk0;
        load_pkt(1'b1, 1'b1, 9'd80, TS_NOW, 1'b0, s);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            bus.tx_strobe = 1'b1;
            tick();
        end
        bus.tx_strobe = 1'b0;
        @(negedge txclk);
        checks++;
        if ({bus.tx_q, bus.tx_i} !== slot_mem[s][11] || bus.in_burst !== 1'b1) begin
            errors++; $display("FAIL mid_progress got %h in_burst=%b want %h 1", {bus.tx_q, bus.tx_i}, bus.in_burst, slot_mem[s][11]);
        end
        sk0 = n_skip;
        reset = 1'b1;
        tick();
        @(negedge txclk);
        checks++;
        if ({bus.rdreq, bus.skip, bus.underrun, bus.dropped, bus.in_burst} !== 5'b0 || {bus.tx_i, bus.tx_q} !== 32'h0) begin
            errors++; $display("FAIL mid_reset got ctrl=%b tx=%h want 0 0", {bus.rdreq, bus.skip, bus.underrun, bus.dropped, bus.in_burst}, {bus.tx_i, bus.tx_q});
        end
        tick();
        reset = 1'b0;
        burst_m = 1'b0;
        tick();
        @(negedge txclk);
        checks++;
        if (bus.rdreq !== 1'b0 || bus.skip !== 1'b0 || n_skip !== sk0) begin
            errors++; $display("FAIL mid_after got rdreq=%b skip=%b skips=%0d want 0 0 %0d", bus.rdreq, bus.skip, n_skip, sk0);
        end
        tick();
    endtask

    initial begin
        bus.tx_strobe = 1'b0;
        bus.adc_time  = 32'd0;
        test_reset();
        test_basic();
        test_wait_ts(32'd1000);
        test_wait_ts(32'd5000 + 32'($urandom_range(0, 1000)));
        test_drop();
        test_lengths();
        test_random();
        test_underrun();
        test_reset_mid();
        checks++;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL rdreq_skip_overlap got 1 want 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
